mat_stream_buf: RTL

MAT_STREAM_BUF -- requirements
Module: mat_stream_buf

---
 rtl/mat_stream_buf.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mat_stream_buf.sv
// Banked matrix buffer streaming one row per output lane, lane r skewed by r cycles.
// Optional even-parity protection per word is enabled by defining MAT_BUF_PARITY_EN.
module mat_stream_buf #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int WORD_SIZE = 16,
    parameter int INIT_VAL  = 1,
    localparam int ADDR_WIDTH = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [ADDR_WIDTH-1:0]     wr_addr,
    input  logic [WORD_SIZE-1:0]      wr_data,
    output logic                      wr_ready,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [ROWS*WORD_SIZE-1:0] out_vec,
    output logic [ROWS-1:0]           out_valid,
    output logic [ROWS-1:0]           par_err
);

    localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CNTMAX = (ROWS > COLS) ? ROWS : COLS;
    localparam int CNTW   = $clog2(CNTMAX + 1);
    localparam logic [WORD_SIZE-1:0] INIT_W = WORD_SIZE'(INIT_VAL);

`ifdef MAT_BUF_PARITY_EN
    localparam int BW = WORD_SIZE + 1;
    localparam logic [BW-1:0] INIT_WORD = {^INIT_W, INIT_W};
`else
    localparam int BW = WORD_SIZE;
    localparam logic [BW-1:0] INIT_WORD = INIT_W;
`endif

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_e;

    state_e          state_q;
    logic [CNTW-1:0] cnt_q;
    logic            busy_q;
    logic            done_q;
    logic            wr_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_ready_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= STREAM;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        wr_ready_q <= 1'b0;
                    end
                end
                STREAM: begin
                    if (cnt_q == CNTW'(COLS - 1)) begin
                        state_q <= DRAIN;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNTW'(1);
                    end
                end
                DRAIN: begin
                    // ROWS drain cycles cover the deepest skew stage of the last lane
                    if (cnt_q == CNTW'(ROWS - 1)) begin
                        state_q    <= IDLE;
                        cnt_q      <= '0;
                        busy_q     <= 1'b0;
                        wr_ready_q <= 1'b1;
                        done_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNTW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign wr_ready = wr_ready_q;

    logic            wr_acc;
    int unsigned     wr_row;
    logic [CW-1:0]   wr_col;
    logic [BW-1:0]   wr_word;
    logic            rd_en;
    logic [CW-1:0]   rd_col;
    logic            start_acc;

    always_comb begin
        wr_row = 32'(wr_addr) / COLS;
        wr_col = CW'(32'(wr_addr) % COLS);
        wr_acc = wr_en && wr_ready_q &&
                 ({1'b0, wr_addr} < (ADDR_WIDTH + 1)'(ROWS * COLS));
    end

`ifdef MAT_BUF_PARITY_EN
    assign wr_word = {^wr_data, wr_data};
`else
    assign wr_word = wr_data;
`endif

    assign rd_en     = (state_q == STREAM);
    assign rd_col    = cnt_q[CW-1:0];
    assign start_acc = start && (state_q == IDLE);

    for (genvar r = 0; r < ROWS; r++) begin : g_bank
        logic [BW-1:0]        bank_q [COLS] = '{default: INIT_WORD};
        logic [BW-1:0]        rd_word;
        logic [WORD_SIZE-1:0] pipe_q [r+1];
        logic [r:0]           vld_q;

        always_ff @(posedge clk) begin
            if (wr_acc && (wr_row == r)) begin
                bank_q[wr_col] <= wr_word;
            end
        end

        assign rd_word = bank_q[rd_col];

        // Stage 0 is the registered bank read; stages 1..r add the lane skew
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned i = 0; i <= r; i++) begin
                    pipe_q[i] <= '0;
                end
                vld_q <= '0;
            end else begin
                pipe_q[0] <= rd_en ? rd_word[WORD_SIZE-1:0] : '0;
                vld_q[0]  <= rd_en;
                for (int unsigned i = 1; i <= r; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                    vld_q[i]  <= vld_q[i-1];
                end
            end
        end

        assign out_vec[r*WORD_SIZE +: WORD_SIZE] = pipe_q[r];
        assign out_valid[r]                      = vld_q[r];

`ifdef MAT_BUF_PARITY_EN
        logic err_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                err_q <= 1'b0;
            end else if (start_acc) begin
                err_q <= 1'b0;
            end else if (rd_en && (^rd_word)) begin
                err_q <= 1'b1;
            end
        end

        assign par_err[r] = err_q;
`else
        assign par_err[r] = 1'b0;
`endif
    end

endmodule
